// File: rtl/prf_wb_ready_pkg.sv
// prf_wb_ready_pkg: constants and tag type shared by the register file,
// the bypass network and the issue stage.
//   PR_NUM  - number of physical registers
//   PR_W    - physical register tag width
//   DATA_W  - register data width
//   pr_tag_t - physical register tag, tag 0 means "no register"
package prf_wb_ready_pkg;

    localparam int PR_NUM = 64;
    localparam int PR_W   = 6;
    localparam int DATA_W = 32;

    typedef logic [PR_W-1:0]   pr_tag_t;
    typedef logic [DATA_W-1:0] data_t;

    // Writeback request as it leaves the bypass network.
    typedef struct packed {
        pr_tag_t pr;
        data_t   data;
    } wb_req_t;

    // Number of writeback ports and source read ports served by the PRF.
    localparam int NUM_WB = 2;
    localparam int NUM_RD = 4;

endpackage

// File: rtl/prf_ready_table.sv
// prf_ready_table: per-PR ready bits.
//   clk, rst_n      - clock, synchronous active-low reset (all bits -> 1)
//   flush           - pipeline flush, all bits -> 1
//   alloc_vld/pr    - rename allocations, clear the bit (tag 0 ignored)
//   wb_pr           - writeback tags [0]=ALU0 [1]=BRU, set the bit (tag 0 ignored)
//   rd_pr / rd_rdy  - combinational ready lookup with writeback forwarding
//   wb_conflict_err - sticky error, present only with PRF_WB_CONFLICT_CHK_EN
// Update priority: reset > flush > allocation clear > writeback set.
module prf_ready_table
    import prf_wb_ready_pkg::*;
#(
    parameter int PR_NUM_P = PR_NUM,
    parameter int PR_W_P   = PR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [1:0]                     alloc_vld,
    input  logic [1:0][PR_W_P-1:0]         alloc_pr,
    input  logic [NUM_WB-1:0][PR_W_P-1:0]  wb_pr,
    input  logic [NUM_RD-1:0][PR_W_P-1:0]  rd_pr,
    output logic [NUM_RD-1:0]              rd_rdy
`ifdef PRF_WB_CONFLICT_CHK_EN
    ,
    output logic                           wb_conflict_err
`endif
);

    logic [PR_NUM_P-1:0] rdy_q;
    logic [PR_NUM_P-1:0] rdy_d;

    // Allocation is applied after writeback so it wins on a same-tag collision.
    always_comb begin
        rdy_d = rdy_q;
        for (int i = 1; i < PR_NUM_P; i++) begin
            for (int w = 0; w < NUM_WB; w++)
                if (wb_pr[w] == PR_W_P'(i)) rdy_d[i] = 1'b1;
            for (int a = 0; a < 2; a++)
                if (alloc_vld[a] && alloc_pr[a] == PR_W_P'(i)) rdy_d[i] = 1'b0;
        end
        rdy_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     rdy_q <= '1;
        else if (flush) rdy_q <= '1;
        else            rdy_q <= rdy_d;
    end

    // A nonzero read tag matching a writeback tag implies that writeback is live.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign rd_rdy[g] = (rd_pr[g] == '0)
                        || (rd_pr[g] == wb_pr[0])
                        || (rd_pr[g] == wb_pr[1])
                        || rdy_q[rd_pr[g]];
    end

`ifdef PRF_WB_CONFLICT_CHK_EN
    logic [NUM_WB-1:0] dbl_wb;
    logic              same_wb;
    logic              err_q;

    // A writeback into a PR that is already ready, and not being reallocated
    // in this same cycle, means some producer wrote twice.
    for (genvar w = 0; w < NUM_WB; w++) begin : g_dbl
        assign dbl_wb[w] = (wb_pr[w] != '0) && rdy_q[wb_pr[w]]
                        && !(alloc_vld[0] && alloc_pr[0] == wb_pr[w])
                        && !(alloc_vld[1] && alloc_pr[1] == wb_pr[w]);
    end
    assign same_wb = (wb_pr[0] != '0) && (wb_pr[0] == wb_pr[1]);

    always_ff @(posedge clk) begin
        if (!rst_n)                   err_q <= 1'b0;
        else if (same_wb || |dbl_wb)  err_q <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && (same_wb || |dbl_wb))
            $error("prf_ready_table: writeback conflict tags %0d/%0d", wb_pr[0], wb_pr[1]);
    end
`endif

    assign wb_conflict_err = err_q;
`endif

endmodule

// File: rtl/prf_wb_ready.sv
// prf_wb_ready: physical register file with ready-bit table.
//   clk, rst_n                 - clock, synchronous active-low reset
//   ALU0_PR/data_bypass        - ALU0 writeback, tag 0 = no write
//   BRU_PR/data_bypass         - BRU writeback, tag 0 = no write
//   alloc0/1_vld, alloc0/1_pr  - rename destination allocations
//   flush                      - pipeline flush (ready bits only)
//   rd_pr0..3                  - source read tags
//   rd_data0..3, rd_rdy0..3    - combinational read data / ready, same-cycle
//                                writeback forwarded (BRU over ALU0)
//   wb_conflict_err            - only with macro PRF_WB_CONFLICT_CHK_EN
module prf_wb_ready
    import prf_wb_ready_pkg::*;
#(
    parameter int PR_NUM_P = PR_NUM,
    parameter int PR_W_P   = PR_W,
    parameter int DATA_W_P = DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PR_W_P-1:0]   ALU0_PR_bypass,
    input  logic [DATA_W_P-1:0] ALU0_data_bypass,
    input  logic [PR_W_P-1:0]   BRU_PR_bypass,
    input  logic [DATA_W_P-1:0] BRU_data_bypass,
    input  logic                alloc0_vld,
    input  logic [PR_W_P-1:0]   alloc0_pr,
    input  logic                alloc1_vld,
    input  logic [PR_W_P-1:0]   alloc1_pr,
    input  logic                flush,
    input  logic [PR_W_P-1:0]   rd_pr0,
    input  logic [PR_W_P-1:0]   rd_pr1,
    input  logic [PR_W_P-1:0]   rd_pr2,
    input  logic [PR_W_P-1:0]   rd_pr3,
    output logic [DATA_W_P-1:0] rd_data0,
    output logic [DATA_W_P-1:0] rd_data1,
    output logic [DATA_W_P-1:0] rd_data2,
    output logic [DATA_W_P-1:0] rd_data3,
    output logic                rd_rdy0,
    output logic                rd_rdy1,
    output logic                rd_rdy2,
    output logic                rd_rdy3
`ifdef PRF_WB_CONFLICT_CHK_EN
    ,
    output logic                wb_conflict_err
`endif
);

    logic [NUM_RD-1:0][PR_W_P-1:0]   rd_pr;
    logic [NUM_RD-1:0][DATA_W_P-1:0] rd_data;
    logic [NUM_RD-1:0]               rd_rdy;
    logic [NUM_WB-1:0][PR_W_P-1:0]   wb_pr;
    logic [1:0][PR_W_P-1:0]          alloc_pr;

    logic [DATA_W_P-1:0] mem_q [PR_NUM_P];

    assign rd_pr    = {rd_pr3, rd_pr2, rd_pr1, rd_pr0};
    assign wb_pr    = {BRU_PR_bypass, ALU0_PR_bypass};
    assign alloc_pr = {alloc1_pr, alloc0_pr};

    // BRU is written last so it wins the (illegal) same-tag double write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PR_NUM_P; i++) mem_q[i] <= '0;
        end else begin
            if (ALU0_PR_bypass != '0) mem_q[ALU0_PR_bypass] <= ALU0_data_bypass;
            if (BRU_PR_bypass  != '0) mem_q[BRU_PR_bypass]  <= BRU_data_bypass;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        always_comb begin
            if (rd_pr[g] == '0)                  rd_data[g] = '0;
            else if (rd_pr[g] == BRU_PR_bypass)  rd_data[g] = BRU_data_bypass;
            else if (rd_pr[g] == ALU0_PR_bypass) rd_data[g] = ALU0_data_bypass;
            else                                 rd_data[g] = mem_q[rd_pr[g]];
        end
    end

    prf_ready_table #(
        .PR_NUM_P (PR_NUM_P),
        .PR_W_P   (PR_W_P)
    ) u_rdy (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alloc_vld ({alloc1_vld, alloc0_vld}),
        .alloc_pr  (alloc_pr),
        .wb_pr     (wb_pr),
        .rd_pr     (rd_pr),
        .rd_rdy    (rd_rdy)
`ifdef PRF_WB_CONFLICT_CHK_EN
        ,
        .wb_conflict_err (wb_conflict_err)
`endif
    );

    assign rd_data0 = rd_data[0];
    assign rd_data1 = rd_data[1];
    assign rd_data2 = rd_data[2];
    assign rd_data3 = rd_data[3];
    assign rd_rdy0  = rd_rdy[0];
    assign rd_rdy1  = rd_rdy[1];
    assign rd_rdy2  = rd_rdy[2];
    assign rd_rdy3  = rd_rdy[3];

endmodule

// File: tb/tb_prf_wb_ready.sv
// tb_prf_wb_ready: directed stimulus, a per-PR reference model updated at
// every posedge, a per-cycle compare of all four read lanes, and literal
// checks at the interesting points. Conflict flag checks are compiled in
// with PRF_WB_CONFLICT_CHK_EN.
module tb_prf_wb_ready;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ALU0_PR_bypass, BRU_PR_bypass;
    logic [31:0] ALU0_data_bypass, BRU_data_bypass;
    logic        alloc0_vld, alloc1_vld, flush;
    logic [5:0]  alloc0_pr, alloc1_pr;
    logic [5:0]  rd_pr0, rd_pr1, rd_pr2, rd_pr3;
    logic [31:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic        rd_rdy0, rd_rdy1, rd_rdy2, rd_rdy3;
`ifdef PRF_WB_CONFLICT_CHK_EN
    logic        wb_conflict_err;
    logic        m_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prf_wb_ready dut (
        .clk(clk), .rst_n(rst_n),
        .ALU0_PR_bypass(ALU0_PR_bypass), .ALU0_data_bypass(ALU0_data_bypass),
        .BRU_PR_bypass(BRU_PR_bypass), .BRU_data_bypass(BRU_data_bypass),
        .alloc0_vld(alloc0_vld), .alloc0_pr(alloc0_pr),
        .alloc1_vld(alloc1_vld), .alloc1_pr(alloc1_pr),
        .flush(flush),
        .rd_pr0(rd_pr0), .rd_pr1(rd_pr1), .rd_pr2(rd_pr2), .rd_pr3(rd_pr3),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .rd_rdy0(rd_rdy0), .rd_rdy1(rd_rdy1), .rd_rdy2(rd_rdy2), .rd_rdy3(rd_rdy3)
`ifdef PRF_WB_CONFLICT_CHK_EN
        , .wb_conflict_err(wb_conflict_err)
`endif
    );

    // ---------------- reference model ----------------
    logic [31:0] m_data [64];
    logic        m_rdy  [64];
    logic        started = 1'b0;

    function automatic logic allocated(logic [5:0] t);
        return (alloc0_vld && alloc0_pr == t) || (alloc1_vld && alloc1_pr == t);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            started <= 1'b1;
            for (int i = 0; i < 64; i++) begin
                m_data[i] <= 32'h0;
                m_rdy[i]  <= 1'b1;
            end
`ifdef PRF_WB_CONFLICT_CHK_EN
            m_err <= 1'b0;
`endif
        end else begin
            for (int i = 1; i < 64; i++) begin
                logic [5:0] t;
                t = 6'(i);
                if (BRU_PR_bypass == t)       m_data[i] <= BRU_data_bypass;
                else if (ALU0_PR_bypass == t) m_data[i] <= ALU0_data_bypass;
                if (flush)             m_rdy[i] <= 1'b1;
                else if (allocated(t)) m_rdy[i] <= 1'b0;
                else if (ALU0_PR_bypass == t || BRU_PR_bypass == t) m_rdy[i] <= 1'b1;
            end
`ifdef PRF_WB_CONFLICT_CHK_EN
            if ((ALU0_PR_bypass != 0 && ALU0_PR_bypass == BRU_PR_bypass)
                || (ALU0_PR_bypass != 0 && m_rdy[ALU0_PR_bypass] && !allocated(ALU0_PR_bypass))
                || (BRU_PR_bypass  != 0 && m_rdy[BRU_PR_bypass]  && !allocated(BRU_PR_bypass)))
                m_err <= 1'b1;
`endif
        end
    end

    function automatic logic [31:0] exp_data(logic [5:0] t);
        if (t == 0)              return 32'h0;
        if (t == BRU_PR_bypass)  return BRU_data_bypass;
        if (t == ALU0_PR_bypass) return ALU0_data_bypass;
        return m_data[t];
    endfunction

    function automatic logic exp_rdy(logic [5:0] t);
        if (t == 0 || t == BRU_PR_bypass || t == ALU0_PR_bypass) return 1'b1;
        return m_rdy[t];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            logic [5:0]  tg [4];
            logic [31:0] dv [4];
            logic        rv [4];
            tg = '{rd_pr0, rd_pr1, rd_pr2, rd_pr3};
            dv = '{rd_data0, rd_data1, rd_data2, rd_data3};
            rv = '{rd_rdy0, rd_rdy1, rd_rdy2, rd_rdy3};
            for (int l = 0; l < 4; l++) begin
                checks++;
                if (dv[l] !== exp_data(tg[l])) begin
                    failures++;
                    $display("FAIL cmp_data lane%0d tag=%0d got=%h exp=%h t=%0t",
                             l, tg[l], dv[l], exp_data(tg[l]), $time);
                end
                checks++;
                if (rv[l] !== exp_rdy(tg[l])) begin
                    failures++;
                    $display("FAIL cmp_rdy lane%0d tag=%0d got=%b exp=%b t=%0t",
                             l, tg[l], rv[l], exp_rdy(tg[l]), $time);
                end
            end
`ifdef PRF_WB_CONFLICT_CHK_EN
            checks++;
            if (wb_conflict_err !== m_err) begin
                failures++;
                $display("FAIL cmp_err got=%b exp=%b t=%0t", wb_conflict_err, m_err, $time);
            end
`endif
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ALU0_PR_bypass = 0; ALU0_data_bypass = 0;
        BRU_PR_bypass = 0;  BRU_data_bypass = 0;
        alloc0_vld = 0; alloc0_pr = 0; alloc1_vld = 0; alloc1_pr = 0;
        flush = 0;
        rd_pr0 = 0; rd_pr1 = 0; rd_pr2 = 0; rd_pr3 = 0;
        nxt(); nxt();
        rst_n = 1'b1;

        // Reset state on tags 0, 5, 63.
        rd_pr0 = 0; rd_pr1 = 5; rd_pr2 = 63;
        look();
        chk("rst_d0", rd_data0, 32'h0); chk("rst_d5", rd_data1, 32'h0); chk("rst_d63", rd_data2, 32'h0);
        chk("rst_r0", {31'h0, rd_rdy0}, 1); chk("rst_r5", {31'h0, rd_rdy1}, 1); chk("rst_r63", {31'h0, rd_rdy2}, 1);

        // Allocate PR 5: no forwarding of the clear.
        nxt(); alloc0_vld = 1; alloc0_pr = 5; rd_pr0 = 5;
        look(); chk("alloc_pre_rdy", {31'h0, rd_rdy0}, 1);
        nxt(); alloc0_vld = 0;
        look(); chk("alloc_post_rdy", {31'h0, rd_rdy0}, 0);

        // ALU0 writes PR 5, forwarded then stored.
        nxt(); ALU0_PR_bypass = 5; ALU0_data_bypass = 32'hDEADBEEF;
        look(); chk("fwd_d5", rd_data0, 32'hDEADBEEF); chk("fwd_r5", {31'h0, rd_rdy0}, 1);
        nxt(); ALU0_PR_bypass = 0; ALU0_data_bypass = 0;
        look(); chk("stored_d5", rd_data0, 32'hDEADBEEF); chk("stored_r5", {31'h0, rd_rdy0}, 1);

        // Tag 0 writeback is dropped.
        nxt(); ALU0_data_bypass = 32'h1234; rd_pr0 = 0; rd_pr1 = 5;
        look(); chk("tag0_fwd", rd_data0, 32'h0); chk("tag0_d5", rd_data1, 32'hDEADBEEF);
        nxt(); ALU0_data_bypass = 0;
        look(); chk("tag0_after", rd_data0, 32'h0); chk("tag0_d5_after", rd_data1, 32'hDEADBEEF);

        // Alloc 9/10, then flush with a BRU write to 9.
        nxt(); alloc0_vld = 1; alloc0_pr = 9; alloc1_vld = 1; alloc1_pr = 10; rd_pr0 = 9; rd_pr1 = 10;
        nxt(); alloc0_vld = 0; alloc1_vld = 0;
        look(); chk("alloc_r9", {31'h0, rd_rdy0}, 0); chk("alloc_r10", {31'h0, rd_rdy1}, 0);
        nxt(); flush = 1; BRU_PR_bypass = 9; BRU_data_bypass = 32'h77;
        nxt(); flush = 0; BRU_PR_bypass = 0; BRU_data_bypass = 0;
        look();
        chk("flush_r9", {31'h0, rd_rdy0}, 1); chk("flush_r10", {31'h0, rd_rdy1}, 1);
        chk("flush_d9", rd_data0, 32'h77);    chk("flush_d10", rd_data1, 32'h0);

        // Same-cycle alloc and writeback of PR 12: allocation wins.
        nxt(); alloc0_vld = 1; alloc0_pr = 12; ALU0_PR_bypass = 12; ALU0_data_bypass = 32'hAA; rd_pr0 = 12;
        look(); chk("aw_fwd_d12", rd_data0, 32'hAA); chk("aw_fwd_r12", {31'h0, rd_rdy0}, 1);
        nxt(); alloc0_vld = 0; ALU0_PR_bypass = 0; ALU0_data_bypass = 0;
        look(); chk("aw_r12", {31'h0, rd_rdy0}, 0); chk("aw_d12", rd_data0, 32'hAA);

        // Both ports write PR 20: BRU wins.
        nxt(); alloc0_vld = 1; alloc0_pr = 20; rd_pr0 = 20;
        nxt(); alloc0_vld = 0;
        ALU0_PR_bypass = 20; ALU0_data_bypass = 32'h1; BRU_PR_bypass = 20; BRU_data_bypass = 32'h2;
        look(); chk("dup_fwd_d20", rd_data0, 32'h2);
        nxt(); ALU0_PR_bypass = 0; ALU0_data_bypass = 0; BRU_PR_bypass = 0; BRU_data_bypass = 0;
        look(); chk("dup_d20", rd_data0, 32'h2); chk("dup_r20", {31'h0, rd_rdy0}, 1);
`ifdef PRF_WB_CONFLICT_CHK_EN
        chk("err_set", {31'h0, wb_conflict_err}, 1);
        nxt(); look(); chk("err_hold", {31'h0, wb_conflict_err}, 1);
`endif

        // BRU and ALU0 on different tags, read from all lanes.
        nxt(); alloc0_vld = 1; alloc0_pr = 30; alloc1_vld = 1; alloc1_pr = 31;
        nxt(); alloc0_vld = 0; alloc1_vld = 0;
        ALU0_PR_bypass = 30; ALU0_data_bypass = 32'h30; BRU_PR_bypass = 31; BRU_data_bypass = 32'h31;
        rd_pr0 = 30; rd_pr1 = 31; rd_pr2 = 31; rd_pr3 = 30;
        look();
        chk("mix_l0", rd_data0, 32'h30); chk("mix_l1", rd_data1, 32'h31);
        chk("mix_l2", rd_data2, 32'h31); chk("mix_l3", rd_data3, 32'h30);

        // Reset mid-operation with a pending write to PR 40.
        nxt(); ALU0_PR_bypass = 0; ALU0_data_bypass = 0; BRU_PR_bypass = 0; BRU_data_bypass = 0;
        alloc0_vld = 1; alloc0_pr = 40;
        nxt(); alloc0_vld = 0; rst_n = 0; ALU0_PR_bypass = 40; ALU0_data_bypass = 32'h55;
        rd_pr0 = 40; rd_pr1 = 5; rd_pr2 = 20; rd_pr3 = 0;
        nxt(); rst_n = 1; ALU0_PR_bypass = 0; ALU0_data_bypass = 0;
        look();
        chk("rst2_d40", rd_data0, 32'h0); chk("rst2_r40", {31'h0, rd_rdy0}, 1);
        chk("rst2_d5", rd_data1, 32'h0);  chk("rst2_d20", rd_data2, 32'h0);
`ifdef PRF_WB_CONFLICT_CHK_EN
        chk("err_clr", {31'h0, wb_conflict_err}, 0);
`endif
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prf_wb_ready.md
Name: prf_wb_ready

Overview:
Physical register file plus ready-bit table, directly downstream of the execute-stage bypass network. Consumes the two gated writeback streams (ALU0, BRU), where PR 0 means "no write". Serves four combinational source reads with same-cycle write forwarding. Tracks per-PR ready bits, which rename clears and writeback sets.

Parameters:
PR_NUM, 64, number of physical registers.
PR_W, 6, physical register tag width (log2 PR_NUM).
DATA_W, 32, data width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
ALU0_PR_bypass  in  PR_W  ALU0 writeback tag; 0 = no write.
ALU0_data_bypass  in  DATA_W  ALU0 writeback data.
BRU_PR_bypass  in  PR_W  BRU writeback tag; 0 = no write.
BRU_data_bypass  in  DATA_W  BRU writeback data.
alloc0_vld, alloc1_vld  in  1 each  rename allocating a destination PR this cycle.
alloc0_pr, alloc1_pr  in  PR_W each  allocated PR tags.
flush  in  1  pipeline flush (mispredict/exception).
rd_pr0..rd_pr3  in  PR_W each  source read tags (issue slot0 src1/src2, slot1 src1/src2).
rd_data0..rd_data3  out  DATA_W each  read data.
rd_rdy0..rd_rdy3  out  1 each  ready bit of the read tag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all PRF entries cleared to 0;
  - all ready bits set to 1;
  - outputs follow combinationally (rd_data*=0, rd_rdy*=1).
  - Reset mid-operation discards all pending state; no write occurs in that cycle.
- Write:
  - A port with a nonzero tag writes its data at the posedge.
  - Tag 0 is never written.
  - Entry 0 always reads 0 and ready=1.
- Both ports writing the same nonzero tag in one cycle is illegal. Defined result: BRU data wins.
- Read: combinational, 0-cycle latency. Forwarding priority for rd_data:
  1. tag 0 -> 0;
  2. BRU tag match -> BRU_data_bypass;
  3. ALU0 tag match -> ALU0_data_bypass;
  4. stored entry.
- rd_rdy:
  - 1 if tag is 0, or matches a same-cycle writeback tag;
  - otherwise the stored ready bit.
  - Allocation does not forward: rd_rdy reflects the pre-clear value in the allocation cycle.
- Ready update at posedge, priority high to low:
  1. reset (all 1);
  2. flush (all 1: every in-flight producer is squashed and freed; reallocation clears again);
  3. allocation clear (alloc*_vld with nonzero tag -> 0);
  4. writeback set (nonzero tag -> 1).
- Flush does not touch PRF data. Writebacks in the flush cycle still write data.
- Allocation with tag 0 is ignored.
- alloc0_pr==alloc1_pr (both valid) is illegal; the bit simply clears.
- Same tag allocated and written back in one cycle: allocation wins (ready=0), data is still written.
- No handshake and no backpressure; every write is accepted in its cycle.

Optional Feature:
Macro PRF_WB_CONFLICT_CHK_EN.
- Defined:
  - adds output wb_conflict_err (1 bit, reset 0).
  - Sticky; set at posedge when both writeback tags are equal and nonzero, or when a writeback targets a PR whose ready bit is already 1 and which is not allocated this cycle (double writeback).
  - Cleared only by reset.
  - Simulation also emits $error.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: PR_W, PR_NUM, DATA_W constants, plus typedef pr_tag_t (logic [PR_W-1:0]), shared with the bypass and issue stages.
- One natural sub-module, prf_ready_table: owns the ready bits, alloc/flush/wakeup priority and the rd_rdy forwarding.
- The parent owns the data array and data forwarding.

Test Plan:
- Reset, then read tags 0, 5, 63 -> rd_data=0, rd_rdy=1 for all.
- Alloc PR 5, then ALU0 writes PR 5 = 0xDEADBEEF:
  - in the write cycle, rd_pr0=5 -> rd_data0=0xDEADBEEF, rd_rdy0=1 (forwarded);
  - next cycle the stored value is identical.
- Writeback with ALU0_PR_bypass=0, data 0x1234 -> no entry changes; rd_pr=0 still returns 0.
- Alloc PR 9 and PR 10 (both cleared), then assert flush with BRU writing PR 9 = 0x77 in the same cycle:
  - after the edge, both ready=1;
  - PR 9 data = 0x77, PR 10 data unchanged.
- Same cycle: alloc PR 12 and ALU0 writeback to PR 12 = 0xAA -> after the edge, ready(12)=0 and data(12)=0xAA.
- With PRF_WB_CONFLICT_CHK_EN: ALU0 and BRU both target PR 20 (0x1, 0x2):
  - stored 0x2;
  - wb_conflict_err=1 next cycle, holding until rst_n=0.
